// File: rtl/array_distributor.sv
// Scatter buffer: accepts K (address, data) lanes per beat, fills a SIZE-slot
// frame over SIZE/K beats, then holds the whole frame until the consumer takes it.
//
// state | meaning
// FILL  | accepting beats; outputs show the partial buffer
// HOLD  | frame complete; outputs frozen until out_ready
module array_distributor #(
    parameter  int SIZE = 16,
    parameter  int K    = 4,
    localparam int AW   = $clog2(SIZE),
    localparam int DW   = $clog2(K) + $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW*K-1:0]      in_addr,
    input  logic [DW*K-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW*SIZE-1:0]   out_array,
    output logic [SIZE-1:0]      out_mask,
    output logic                 collision,
    output logic                 range_err
);

    localparam int BEATS = SIZE / K;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [AW:0]   SIZE_W    = (AW + 1)'(SIZE);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [SIZE-1:0][DW-1:0]     arr_q;
    logic [SIZE-1:0][DW-1:0]     arr_n;
    logic [SIZE-1:0]             mask_n;
    logic                        coll_n;
    logic                        rerr_n;
    logic                        accept;

    assign accept    = in_valid && in_ready;
    assign out_array = arr_q;

    // Lanes are applied in ascending order so the highest lane wins a shared
    // slot; an already-set mask bit (earlier lane or earlier beat) flags collision.
    always_comb begin
        arr_n  = arr_q;
        mask_n = out_mask;
        coll_n = collision;
        rerr_n = range_err;
        for (int i = 0; i < K; i++) begin
            if ({1'b0, in_addr[i*AW +: AW]} >= SIZE_W)
                rerr_n = 1'b1;
            for (int j = 0; j < SIZE; j++) begin
                if (in_addr[i*AW +: AW] == AW'(j)) begin
                    if (mask_n[j])
                        coll_n = 1'b1;
                    mask_n[j] = 1'b1;
                    arr_n[j]  = in_data[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            arr_q     <= '0;
            out_mask  <= '0;
            collision <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        arr_q     <= arr_n;
                        out_mask  <= mask_n;
                        collision <= coll_n;
                        range_err <= rerr_n;
                        if (cnt == LAST_BEAT) begin
                            cnt       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= FILL;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        arr_q     <= '0;
                        out_mask  <= '0;
                        collision <= 1'b0;
                        range_err <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_distributor.sv
// Bench for array_distributor: a 16/4 and a 12/4 instance driven from directed
// and random frames, compared against a per-frame scatter model.
module tb_array_distributor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   sel  = 0;
    logic v    = 1'b0;
    logic ordy = 1'b0;
    logic [15:0] addr = '0;
    logic [23:0] data = '0;

    logic        rdy0, val0, coll0, rerr0;
    logic [95:0] arr0;
    logic [15:0] mask0;
    logic        rdy1, val1, coll1, rerr1;
    logic [71:0] arr1;
    logic [11:0] mask1;

    array_distributor #(.SIZE(16), .K(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v && sel == 0), .in_ready(rdy0),
        .in_addr(addr), .in_data(data), .out_valid(val0), .out_ready(ordy && sel == 0),
        .out_array(arr0), .out_mask(mask0), .collision(coll0), .range_err(rerr0));

    array_distributor #(.SIZE(12), .K(4)) dut12 (
        .clk(clk), .rst(rst), .in_valid(v && sel == 1), .in_ready(rdy1),
        .in_addr(addr), .in_data(data), .out_valid(val1), .out_ready(ordy && sel == 1),
        .out_array(arr1), .out_mask(mask1), .collision(coll1), .range_err(rerr1));

    logic        r_rdy, r_val, r_coll, r_rerr;
    logic [95:0] r_arr;
    logic [15:0] r_mask;
    always_comb begin
        r_rdy  = (sel == 1) ? rdy1  : rdy0;
        r_val  = (sel == 1) ? val1  : val0;
        r_coll = (sel == 1) ? coll1 : coll0;
        r_rerr = (sel == 1) ? rerr1 : rerr0;
        r_arr  = (sel == 1) ? {24'b0, arr1} : arr0;
        r_mask = (sel == 1) ? {4'b0, mask1} : mask0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame stimulus and reference model state
    logic [3:0]  ba[4][4];
    logic [5:0]  bd[4][4];
    logic [5:0]  exp_arr[16];
    logic [15:0] exp_mask;
    logic        exp_coll, exp_rerr;
    int          cur_size;

    task automatic model_clear(input int size);
        cur_size = size;
        for (int j = 0; j < 16; j++) exp_arr[j] = '0;
        exp_mask = '0;
        exp_coll = 1'b0;
        exp_rerr = 1'b0;
    endtask

    task automatic model_apply(input int b);
        for (int i = 0; i < 4; i++) begin
            if (int'(ba[b][i]) >= cur_size) begin
                exp_rerr = 1'b1;
            end else begin
                if (exp_mask[ba[b][i]]) exp_coll = 1'b1;
                exp_arr[ba[b][i]]  = bd[b][i];
                exp_mask[ba[b][i]] = 1'b1;
            end
        end
    endtask

    function automatic logic [95:0] pack_exp();
        logic [95:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[j*6 +: 6] = exp_arr[j];
        return r;
    endfunction

    task automatic check_frame(input string tag);
        check({tag, "_arr"},  r_arr,  pack_exp());
        check({tag, "_mask"}, r_mask, exp_mask);
        check({tag, "_coll"}, r_coll, exp_coll);
        check({tag, "_rerr"}, r_rerr, exp_rerr);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_rdy"},  r_rdy,  1);
        check({tag, "_val"},  r_val,  0);
        check({tag, "_arr"},  r_arr,  0);
        check({tag, "_mask"}, r_mask, 0);
        check({tag, "_coll"}, r_coll, 0);
        check({tag, "_rerr"}, r_rerr, 0);
    endtask

    task automatic beat(input int b, input bit last);
        v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[i*4 +: 4] = ba[b][i];
            data[i*6 +: 6] = bd[b][i];
        end
        check("beat_rdy", r_rdy, 1);
        model_apply(b);
        @(posedge clk); #1;
        v = 1'b0;
        check("beat_val", r_val, {95'b0, last});
        check_frame("beat");
    endtask

    task automatic idle();
        v = 1'b0;
        @(posedge clk); #1;
        check("idle_val", r_val, 0);
        check("idle_mask", r_mask, exp_mask);
    endtask

    task automatic hold_release(input int stall);
        for (int s = 0; s < stall; s++) begin
            ordy = 1'b0;
            v    = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            data = 24'($urandom);
            @(posedge clk); #1;
            check("hold_val", r_val, 1);
            check("hold_rdy", r_rdy, 0);
            check_frame("hold");
        end
        v    = 1'b0;
        ordy = 1'b1;
        check("rel_val", r_val, 1);
        @(posedge clk); #1;
        ordy = 1'b0;
        check_empty("release");
        model_clear(cur_size);
    endtask

    task automatic send_frame(input int s, input int gapmode, input int stall);
        int nb;
        sel = s;
        nb  = (s == 1) ? 3 : 4;
        model_clear((s == 1) ? 12 : 16);
        for (int b = 0; b < nb; b++) begin
            if (gapmode == 1 && b > 0) idle();
            else if (gapmode == 2 && $urandom_range(0, 1) == 1) idle();
            beat(b, b == nb - 1);
        end
        hold_release(stall);
    endtask

    task automatic fill_default();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++) begin
                ba[b][i] = 4'(4*b + i);
                bd[b][i] = 6'(4*b + i + 1);
            end
    endtask

    initial begin
        logic found;
        // Reset values of both instances
        repeat (2) @(posedge clk);
        #1;
        sel = 0; check_empty("reset16");
        sel = 1; check_empty("reset12");
        rst = 1'b0;

        // Identity frame
        fill_default();
        send_frame(0, 0, 0);

        fill_default();
        sel = 0; model_clear(16);
        for (int b = 0; b < 4; b++) beat(b, b == 3);
        check("id_mask", r_mask, 16'hFFFF);
        check("id_slot15", r_arr[15*6 +: 6], 16);
        hold_release(0);

        // Intra-beat collision on slot 5
        fill_default();
        for (int i = 0; i < 4; i++) begin
            ba[0][i] = 4'd5;
            bd[0][i] = 6'(10 + i);
        end
        ba[1] = '{4'd0, 4'd1, 4'd2, 4'd3};
        ba[2] = '{4'd6, 4'd7, 4'd8, 4'd9};
        ba[3] = '{4'd10, 4'd11, 4'd12, 4'd13};
        sel = 0; model_clear(16);
        for (int b = 0; b < 4; b++) beat(b, b == 3);
        check("intra_slot5", r_arr[5*6 +: 6], 13);
        check("intra_coll", r_coll, 1);
        hold_release(1);

        // Cross-beat overwrite of slot 2
        ba[0] = '{4'd2, 4'd0, 4'd1, 4'd3};
        ba[1] = '{4'd4, 4'd6, 4'd7, 4'd8};
        ba[2] = '{4'd9, 4'd2, 4'd10, 4'd11};
        ba[3] = '{4'd12, 4'd13, 4'd14, 4'd15};
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++) bd[b][i] = 6'(ba[b][i] + 20);
        bd[0][0] = 6'd7;
        bd[2][1] = 6'd9;
        sel = 0; model_clear(16);
        for (int b = 0; b < 4; b++) beat(b, b == 3);
        check("cross_slot2", r_arr[2*6 +: 6], 9);
        check("cross_coll", r_coll, 1);
        check("cross_mask2", r_mask[2], 1);
        hold_release(0);

        // Backpressure: gapped input, three stalled HOLD cycles
        fill_default();
        send_frame(0, 1, 3);

        // Range error on the 12-slot instance
        ba[0] = '{4'd0, 4'd1, 4'd2, 4'd13};
        ba[1] = '{4'd3, 4'd4, 4'd5, 4'd6};
        ba[2] = '{4'd7, 4'd8, 4'd9, 4'd10};
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 4; i++) bd[b][i] = 6'(ba[b][i] + 20);
        bd[0][3] = 6'd5;
        sel = 1; model_clear(12);
        for (int b = 0; b < 3; b++) beat(b, b == 2);
        check("range_err", r_rerr, 1);
        check("range_mask", r_mask, 16'h07FF);
        found = 1'b0;
        for (int j = 0; j < 12; j++) if (r_arr[j*6 +: 6] == 6'd5) found = 1'b1;
        check("range_no5", found, 0);
        hold_release(2);

        // Reset mid-fill
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 4; i++) begin
                ba[b][i] = 4'd5;
                bd[b][i] = 6'(b + i);
            end
        sel = 0; model_clear(16);
        beat(0, 0);
        beat(1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_empty("midrst");
        fill_default();
        model_clear(16);
        for (int b = 0; b < 4; b++) beat(b, b == 3);
        hold_release(0);

        // Random frames on both instances
        for (int f = 0; f < 24; f++) begin
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 4; i++) begin
                    ba[b][i] = 4'($urandom_range(0, 15));
                    bd[b][i] = 6'($urandom);
                end
            send_frame(int'($urandom_range(0, 1)), 2, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_distributor.md
# array_distributor

Scatter-side counterpart of the multi-lane selector. The selector gathers elements from a flattened array by address. This block does the reverse: it accepts K (address, data) pairs per beat over a valid/ready handshake and writes each data word into the addressed slot of a SIZE-entry buffer. After SIZE/K beats it presents the whole buffer as one flattened frame, with a written-slot mask and error flags, under a second valid/ready handshake.

## Interface
- SIZE, 16, number of buffer slots; SIZE % K == 0 required
- K, 4, lanes per input beat
- AW, $clog2(SIZE), address width per lane (derived)
- DW, $clog2(K)+$clog2(SIZE), data width per element (derived; matches selector element width)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_addr  in  AW*K  lane i address at [i*AW +: AW]
- in_data  in  DW*K  lane i data at [i*DW +: DW]
- out_valid  out  1  frame complete and held
- out_ready  in  1  consumer takes the frame
- out_array  out  DW*SIZE  slot j at [j*DW +: DW]; unwritten slots read 0
- out_mask  out  SIZE  bit j set if slot j was written this frame
- collision  out  1  sticky: a slot was written more than once this frame
- range_err  out  1  sticky: a lane address was >= SIZE this frame

## Operation
- BEATS = SIZE/K. Beat counter width is $clog2(BEATS), minimum 1.
- Two states: FILL and HOLD.
- FILL
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - On acceptance, each lane with addr < SIZE writes in_data lane to slot addr and sets out_mask[addr].
  - A lane with addr >= SIZE is dropped and sets range_err.
  - Intra-beat conflict (several lanes, same address): the highest lane index wins, and collision is set.
  - Cross-beat conflict (write to a slot whose mask bit is already 1): the new value overwrites, and collision is set.
  - The beat counter increments on each accepted beat. When the accepted beat is beat BEATS-1, the next state is HOLD.
- HOLD
  - out_valid=1, in_ready=0; in_valid is ignored.
  - out_array, out_mask, collision and range_err are stable.
  - When out_valid && out_ready: next state FILL; the buffer, mask, flags and counter all clear to 0.
- out_array, out_mask and the flags are registered outputs. During FILL they show the partial buffer, which is defined but not meaningful.
- Reset values: state FILL, in_ready=1, out_valid=0, out_array=0, out_mask=0, collision=0, range_err=0, counter=0.

## Timing
- Input acceptance costs 1 cycle per beat. There are no bubbles while in_valid stays high in FILL.
- A slot write is visible on out_array the cycle after its beat is accepted.
- out_valid rises the cycle after the last beat is accepted. Minimum frame period is BEATS+1 cycles.
- Release: in the cycle after the out_valid && out_ready handshake, in_ready=1 and all outputs read 0. A new beat is never accepted in the release cycle itself.
- out_ready low in HOLD stalls indefinitely with outputs unchanged.
- rst high at any edge discards the partial or held frame. The next cycle shows the reset values, and the next frame needs a full BEATS beats.
- rst takes priority over any simultaneous handshake.

## Test plan
- Identity (SIZE=16, K=4): beat b, lane i: addr=4b+i, data=(4b+i)+1, in_valid held high. Required response:
  - out_valid=1 exactly 1 cycle after beat 3 is accepted.
  - Slot j = j+1, out_mask=0xFFFF, collision=0, range_err=0.
- Intra-beat collision: beat 0 with all lanes addr 5 and data 10, 11, 12, 13; beats 1-3 target distinct unused slots. Required response: slot 5 = 13, collision=1.
- Cross-beat overwrite: beat 0 lane 0 writes addr 2, data 7; beat 2 lane 1 writes addr 2, data 9. Required response: slot 2 = 9, collision=1, out_mask bit 2 = 1.
- Backpressure: toggle in_valid 1,0,1,0 during FILL, then hold out_ready=0 for 3 cycles in HOLD. Required response:
  - Only valid cycles advance the counter.
  - In HOLD, outputs stay stable and in_ready=0.
  - After out_ready=1 for one cycle: next cycle in_ready=1, out_mask=0, out_array=0.
- Range error (SIZE=12, K=4): one lane addr 13 with data 5. Required response: that write is dropped, range_err=1, and no slot holds data 5 from that lane.
- Reset mid-fill: pulse rst after 2 accepted beats. Required response:
  - Next cycle out_mask=0 and all flags 0.
  - out_valid rises only after 4 further accepted beats.
